// File: rtl/alu_checker_if.sv
// ALU operand/function/result bus as seen between a stimulus driver and the
// response checker that monitors it.
interface alu_checker_if;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        Signed;
    logic [5:0]  ALUFunc;
    logic [31:0] S;

    modport master (output in_valid, A, B, Signed, ALUFunc, S);
    modport slave  (input  in_valid, A, B, Signed, ALUFunc, S);
endinterface

// File: rtl/alu_checker.sv
// Self-checking ALU response monitor: samples each transaction, recomputes the
// result with a golden model two cycles later and keeps pass/fail statistics.
module alu_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    alu_checker_if.slave     bus,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [31:0]      chk_expected,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] illegal_count,
    output logic             err,
    output logic [5:0]       ff_func,
    output logic [31:0]      ff_a,
    output logic [31:0]      ff_b,
    output logic [31:0]      ff_s
);

    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_SUB = 6'b000001;
    localparam logic [5:0] F_AND = 6'b011000;
    localparam logic [5:0] F_OR  = 6'b011110;
    localparam logic [5:0] F_XOR = 6'b010110;
    localparam logic [5:0] F_NOR = 6'b010001;
    localparam logic [5:0] F_A   = 6'b011010;
    localparam logic [5:0] F_SLL = 6'b100000;
    localparam logic [5:0] F_SRL = 6'b100001;
    localparam logic [5:0] F_SRA = 6'b100011;
    localparam logic [5:0] F_EQ  = 6'b110011;
    localparam logic [5:0] F_NEQ = 6'b110001;
    localparam logic [5:0] F_LT  = 6'b110101;
    localparam logic [5:0] F_LEZ = 6'b111101;
    localparam logic [5:0] F_GEZ = 6'b111001;
    localparam logic [5:0] F_GTZ = 6'b111111;

    logic        s1_valid;
    logic        s1_signed;
    logic [5:0]  s1_func;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic [31:0] s1_s;

    logic [31:0] golden;
    logic        legal;
    logic        match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Golden result of the stage-1 transaction; unknown codes yield 0 and clear legal.
    always_comb begin
        golden = '0;
        legal  = 1'b1;
        case (s1_func)
            F_ADD:   golden = s1_a + s1_b;
            F_SUB:   golden = s1_a - s1_b;
            F_AND:   golden = s1_a & s1_b;
            F_OR:    golden = s1_a | s1_b;
            F_XOR:   golden = s1_a ^ s1_b;
            F_NOR:   golden = ~(s1_a | s1_b);
            F_A:     golden = s1_a;
            F_SLL:   golden = s1_b << s1_a[4:0];
            F_SRL:   golden = s1_b >> s1_a[4:0];
            F_SRA:   golden = $signed(s1_b) >>> s1_a[4:0];
            F_EQ:    golden = {31'b0, s1_a == s1_b};
            F_NEQ:   golden = {31'b0, s1_a != s1_b};
            F_LT:    golden = {31'b0, s1_signed ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b)};
            F_LEZ:   golden = {31'b0, $signed(s1_a) <= 32'sd0};
            F_GEZ:   golden = {31'b0, $signed(s1_a) >= 32'sd0};
            F_GTZ:   golden = {31'b0, $signed(s1_a) > 32'sd0};
            default: legal  = 1'b0;
        endcase
        match = legal && (golden == s1_s);
    end

    // Stage 1 captures the bus; stage 2 scores the captured transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_signed     <= 1'b0;
            s1_func       <= '0;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_s          <= '0;
            chk_valid     <= 1'b0;
            chk_pass      <= 1'b0;
            chk_expected  <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            illegal_count <= '0;
            err           <= 1'b0;
            ff_func       <= '0;
            ff_a          <= '0;
            ff_b          <= '0;
            ff_s          <= '0;
        end else if (clear) begin
            s1_valid      <= 1'b0;
            chk_valid     <= 1'b0;
            chk_pass      <= 1'b0;
            chk_expected  <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            illegal_count <= '0;
            err           <= 1'b0;
            ff_func       <= '0;
            ff_a          <= '0;
            ff_b          <= '0;
            ff_s          <= '0;
        end else begin
            s1_valid  <= bus.in_valid;
            if (bus.in_valid) begin
                s1_signed <= bus.Signed;
                s1_func   <= bus.ALUFunc;
                s1_a      <= bus.A;
                s1_b      <= bus.B;
                s1_s      <= bus.S;
            end
            chk_valid <= s1_valid;
            if (s1_valid) begin
                chk_expected <= golden;
                chk_pass     <= match;
                if (!legal) begin
                    illegal_count <= sat_inc(illegal_count);
                end else if (match) begin
                    pass_count <= sat_inc(pass_count);
                end else begin
                    fail_count <= sat_inc(fail_count);
                    err        <= 1'b1;
                    // Only the first mismatch since reset/clear is kept for debug.
                    if (!err) begin
                        ff_func <= s1_func;
                        ff_a    <= s1_a;
                        ff_b    <= s1_b;
                        ff_s    <= s1_s;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: directed scenarios plus random traffic scored against a
// transaction-level reference model; a second instance runs with 2-bit counters.
module tb_alu_checker;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    always #5 clk = ~clk;

    alu_checker_if bus ();

    logic        chk_valid, chk_pass, err;
    logic [31:0] chk_expected, ff_a, ff_b, ff_s;
    logic [5:0]  ff_func;
    logic [15:0] pass_count, fail_count, illegal_count;

    logic        sm_chk_valid, sm_chk_pass, sm_err;
    logic [31:0] sm_chk_expected, sm_ff_a, sm_ff_b, sm_ff_s;
    logic [5:0]  sm_ff_func;
    logic [1:0]  sm_pass_count, sm_fail_count, sm_illegal_count;

    alu_checker #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .chk_valid(chk_valid), .chk_pass(chk_pass), .chk_expected(chk_expected),
        .pass_count(pass_count), .fail_count(fail_count), .illegal_count(illegal_count),
        .err(err), .ff_func(ff_func), .ff_a(ff_a), .ff_b(ff_b), .ff_s(ff_s)
    );

    alu_checker #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .chk_valid(sm_chk_valid), .chk_pass(sm_chk_pass), .chk_expected(sm_chk_expected),
        .pass_count(sm_pass_count), .fail_count(sm_fail_count), .illegal_count(sm_illegal_count),
        .err(sm_err), .ff_func(sm_ff_func), .ff_a(sm_ff_a), .ff_b(sm_ff_b), .ff_s(sm_ff_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference ALU written with wide integer arithmetic rather than bit operators.
    function automatic logic [31:0] golden(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b, input logic sg, output bit legal);
        longint ua, ub, sa, sb, scale, q;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        scale = longint'(1) << a[4:0];
        legal = 1'b1;
        case (f)
            6'b000000: return 32'(ua + ub);
            6'b000001: return 32'(ua - ub);
            6'b011000: return a & b;
            6'b011110: return a | b;
            6'b010110: return a ^ b;
            6'b010001: return ~(a | b);
            6'b011010: return a;
            6'b100000: return 32'(ub * scale);
            6'b100001: return 32'(ub / scale);
            6'b100011: begin
                q = (sb >= 0) ? sb / scale : -((-sb + scale - 1) / scale);
                return 32'(q);
            end
            6'b110011: return {31'd0, ua == ub};
            6'b110001: return {31'd0, ua != ub};
            6'b110101: return {31'd0, sg ? (sa < sb) : (ua < ub)};
            6'b111101: return {31'd0, sa <= 0};
            6'b111001: return {31'd0, sa >= 0};
            6'b111111: return {31'd0, sa > 0};
            default: begin
                legal = 1'b0;
                return 32'd0;
            end
        endcase
    endfunction

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    typedef struct {
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] s;
    } txn_t;

    txn_t        pend_q[$];
    logic        m_valid = 1'b0;
    logic        m_pass = 1'b0;
    logic [31:0] m_expected = 32'd0;
    int          m_passes = 0;
    int          m_fails = 0;
    int          m_illegals = 0;
    logic        m_err = 1'b0;
    txn_t        m_ff = '{6'd0, 32'd0, 32'd0, 1'b0, 32'd0};

    function automatic void modelFlush();
        pend_q.delete();
        m_valid    = 1'b0;
        m_passes   = 0;
        m_fails    = 0;
        m_illegals = 0;
        m_err      = 1'b0;
        m_ff       = '{6'd0, 32'd0, 32'd0, 1'b0, 32'd0};
    endfunction

    // Scoreboard: each accepted transaction is reported one edge after it is taken.
    always @(posedge clk or posedge reset) begin : model
        txn_t        t;
        bit          lg;
        logic [31:0] g;
        if (reset || clear) begin
            modelFlush();
        end else begin
            m_valid = 1'b0;
            if (pend_q.size() > 0) begin
                t = pend_q.pop_front();
                g = golden(t.func, t.a, t.b, t.sg, lg);
                m_valid    = 1'b1;
                m_expected = g;
                m_pass     = lg && (g == t.s);
                if (!lg) m_illegals++;
                else if (m_pass) m_passes++;
                else begin
                    if (!m_err) m_ff = t;
                    m_err = 1'b1;
                    m_fails++;
                end
            end
            if (bus.in_valid)
                pend_q.push_back('{bus.ALUFunc, bus.A, bus.B, bus.Signed, bus.S});
        end
    end

    always @(negedge clk) begin
        checkOutput("chk_valid", 32'(chk_valid), 32'(m_valid));
        checkOutput("sm_chk_valid", 32'(sm_chk_valid), 32'(m_valid));
        if (m_valid) begin
            checkOutput("chk_pass", 32'(chk_pass), 32'(m_pass));
            checkOutput("chk_expected", chk_expected, m_expected);
            checkOutput("sm_chk_pass", 32'(sm_chk_pass), 32'(m_pass));
            checkOutput("sm_chk_expected", sm_chk_expected, m_expected);
        end
        checkOutput("pass_count", 32'(pass_count), 32'(sat(m_passes, 16)));
        checkOutput("fail_count", 32'(fail_count), 32'(sat(m_fails, 16)));
        checkOutput("illegal_count", 32'(illegal_count), 32'(sat(m_illegals, 16)));
        checkOutput("sm_pass_count", 32'(sm_pass_count), 32'(sat(m_passes, 2)));
        checkOutput("sm_fail_count", 32'(sm_fail_count), 32'(sat(m_fails, 2)));
        checkOutput("sm_illegal_count", 32'(sm_illegal_count), 32'(sat(m_illegals, 2)));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("sm_err", 32'(sm_err), 32'(m_err));
        checkOutput("ff_func", 32'(ff_func), 32'(m_ff.func));
        checkOutput("ff_a", ff_a, m_ff.a);
        checkOutput("ff_b", ff_b, m_ff.b);
        checkOutput("ff_s", ff_s, m_ff.s);
        checkOutput("sm_ff_func", 32'(sm_ff_func), 32'(m_ff.func));
        checkOutput("sm_ff_a", sm_ff_a, m_ff.a);
        checkOutput("sm_ff_b", sm_ff_b, m_ff.b);
        checkOutput("sm_ff_s", sm_ff_s, m_ff.s);
    end

    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic sg, input logic [31:0] s,
                                 input logic clr);
        bus.in_valid = v;
        bus.ALUFunc  = f;
        bus.A        = a;
        bus.B        = b;
        bus.Signed   = sg;
        bus.S        = s;
        clear        = clr;
        @(negedge clk);
        bus.in_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic applyIdle(input int n);
        repeat (n) applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(40));
            default: return $urandom;
        endcase
    endfunction

    localparam logic [5:0] AND_F = 6'b011000;

    logic [5:0] codes [16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110,
                               6'b010110, 6'b010001, 6'b011010, 6'b100000,
                               6'b100001, 6'b100011, 6'b110011, 6'b110001,
                               6'b110101, 6'b111101, 6'b111001, 6'b111111};

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b, s;
        logic        sg, v, clr;
        bit          lg;

        reset = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.ALUFunc  = 6'd0;
        bus.A        = 32'd0;
        bus.B        = 32'd0;
        bus.Signed   = 1'b0;
        bus.S        = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst chk_valid", 32'(chk_valid), 32'd0);
        checkOutput("rst chk_expected", chk_expected, 32'd0);
        checkOutput("rst pass_count", 32'(pass_count), 32'd0);
        checkOutput("rst fail_count", 32'(fail_count), 32'd0);
        checkOutput("rst illegal_count", 32'(illegal_count), 32'd0);
        checkOutput("rst err", 32'(err), 32'd0);
        checkOutput("rst ff_a", ff_a, 32'd0);
        reset = 1'b0;

        // AND 15 & -35 = 0xD, reported two cycles after it is presented.
        applyStimulus(1'b1, AND_F, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000D, 1'b0);
        applyIdle(1);
        checkOutput("and chk_valid", 32'(chk_valid), 32'd1);
        checkOutput("and chk_pass", 32'(chk_pass), 32'd1);
        checkOutput("and chk_expected", chk_expected, 32'h0000_000D);
        checkOutput("and pass_count", 32'(pass_count), 32'd1);

        // Back-to-back SUB then SRA.
        applyStimulus(1'b1, 6'b000001, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(1'b1, 6'b100011, 32'd3, 32'hFFFF_FFDD, 1'b0, 32'hFFFF_FFFB, 1'b0);
        checkOutput("sub chk_valid", 32'(chk_valid), 32'd1);
        checkOutput("sub chk_expected", chk_expected, 32'hFFFF_FFFE);
        applyIdle(1);
        checkOutput("sra chk_valid", 32'(chk_valid), 32'd1);
        checkOutput("sra chk_expected", chk_expected, 32'hFFFF_FFFB);
        checkOutput("sra pass_count", 32'(pass_count), 32'd3);

        // LT unsigned passes, LT signed fails first, corrupted ADD fails second.
        applyStimulus(1'b1, 6'b110101, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 6'b110101, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b0);
        applyStimulus(1'b1, 6'b000000, 32'd2, 32'd3, 1'b0, 32'd0, 1'b0);
        applyIdle(2);
        checkOutput("lt pass_count", 32'(pass_count), 32'd4);
        checkOutput("lt fail_count", 32'(fail_count), 32'd2);
        checkOutput("lt err", 32'(err), 32'd1);
        checkOutput("lt ff_func", 32'(ff_func), 32'(6'b110101));
        checkOutput("lt ff_a", ff_a, 32'hFFFF_FFFF);
        checkOutput("lt ff_b", ff_b, 32'd1);
        checkOutput("lt ff_s", ff_s, 32'd0);

        // Illegal function code after a clear.
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 6'b101010, 32'd7, 32'd9, 1'b0, 32'd0, 1'b0);
        applyIdle(1);
        checkOutput("ill chk_valid", 32'(chk_valid), 32'd1);
        checkOutput("ill chk_pass", 32'(chk_pass), 32'd0);
        checkOutput("ill chk_expected", chk_expected, 32'd0);
        checkOutput("ill illegal_count", 32'(illegal_count), 32'd1);
        checkOutput("ill err", 32'(err), 32'd0);
        checkOutput("ill fail_count", 32'(fail_count), 32'd0);

        // Clear one cycle after a transaction, then a transaction presented with clear.
        applyStimulus(1'b1, AND_F, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000D, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        applyIdle(1);
        checkOutput("clr chk_valid", 32'(chk_valid), 32'd0);
        applyIdle(1);
        checkOutput("clr chk_valid2", 32'(chk_valid), 32'd0);
        checkOutput("clr illegal_count", 32'(illegal_count), 32'd0);
        checkOutput("clr pass_count", 32'(pass_count), 32'd0);
        applyStimulus(1'b1, AND_F, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000D, 1'b1);
        applyIdle(1);
        checkOutput("clrin chk_valid", 32'(chk_valid), 32'd0);
        applyIdle(1);
        checkOutput("clrin chk_valid2", 32'(chk_valid), 32'd0);

        // Saturation of the 2-bit counters.
        repeat (5) applyStimulus(1'b1, AND_F, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000D, 1'b0);
        applyIdle(2);
        checkOutput("sat sm_pass_count", 32'(sm_pass_count), 32'd3);
        checkOutput("sat pass_count", 32'(pass_count), 32'd5);

        // Asynchronous reset between edges, with a result just reported.
        applyStimulus(1'b1, AND_F, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000D, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst chk_valid", 32'(chk_valid), 32'd0);
        checkOutput("arst pass_count", 32'(pass_count), 32'd0);
        checkOutput("arst sm_pass_count", 32'(sm_pass_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset while a transaction sits in stage 1: nothing may emerge afterwards.
        applyStimulus(1'b1, AND_F, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000D, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applyIdle(1);
        checkOutput("rst1 chk_valid", 32'(chk_valid), 32'd0);
        applyIdle(1);
        checkOutput("rst1 chk_valid2", 32'(chk_valid), 32'd0);
        checkOutput("rst1 pass_count", 32'(pass_count), 32'd0);

        // Random traffic with occasional illegal codes, corrupted results and clears.
        for (int i = 0; i < 400; i++) begin
            f = ($urandom_range(99) < 8) ? 6'($urandom) : codes[$urandom_range(15)];
            a = pickOperand();
            b = pickOperand();
            sg = 1'($urandom);
            s = golden(f, a, b, sg, lg);
            if ($urandom_range(3) == 0) s = s ^ (32'd1 << $urandom_range(31));
            v = ($urandom_range(9) != 0);
            clr = ($urandom_range(49) == 0);
            applyStimulus(v, f, a, b, sg, s, clr);
        end
        applyIdle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
